// File: rtl/uart_fifo_pkg.sv
// Shared constants, types and elaboration helpers for the uart_fifo_v2 slice.
package uart_fifo_pkg;

  localparam int unsigned DefaultWidth = 8;
  localparam int unsigned DefaultDepth = 16;
  localparam int unsigned MaxDepth     = 256;

  // Wide enough for any legal occupancy (0..MaxDepth).
  typedef logic [$clog2(MaxDepth):0] count_t;

  function automatic bit is_pow2(input int unsigned n);
    return (n != 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_dpram.sv
// Simple dual-port RAM: one write port, one read port that is registered or combinational.
module fifo_dpram #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 16,
  parameter bit          REG_READ = 1'b1,
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  if (REG_READ) begin : gen_reg_rd
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        rdata_q <= '0;
      end else if (re) begin
        rdata_q <= mem[raddr];
      end
    end

    assign rdata = rdata_q;
  end else begin : gen_comb_rd
    logic unused_rd;
    assign unused_rd = ^{rst, re};
    assign rdata     = mem[raddr];
  end

endmodule

// File: rtl/uart_fifo_v2.sv
// Parametrised UART byte FIFO with occupancy, threshold flags and sticky errors.
// Define UART_FIFO_FWFT_EN for first-word fall-through reads.
module uart_fifo_v2
  import uart_fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = DefaultWidth,
  parameter int unsigned DEPTH     = DefaultDepth,
  parameter int unsigned AF_THRESH = DEPTH - 2,
  parameter int unsigned AE_THRESH = 2,
  localparam int unsigned AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [WIDTH-1:0] data_in,
  input  logic             rd,
  output logic [WIDTH-1:0] data_out,
  output logic             empty,
  output logic             full,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             underflow,
  input  logic             clr_err
);

  if (!is_pow2(DEPTH) || DEPTH < 2 || DEPTH > MaxDepth) begin : gen_depth_check
    $fatal(1, "uart_fifo_v2: DEPTH must be a power of 2 in 2..256");
  end

  localparam count_t AfLevel = count_t'(AF_THRESH);
  localparam count_t AeLevel = count_t'(AE_THRESH);
  localparam logic [AW:0]   FullLevel = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CountOne  = (AW + 1)'(1);
  localparam logic [AW-1:0] PtrOne    = AW'(1);

`ifdef UART_FIFO_FWFT_EN
  localparam bit RegRead = 1'b0;
`else
  localparam bit RegRead = 1'b1;
`endif

  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             wr_acc, rd_acc;
  logic [WIDTH-1:0] rdata;

  assign empty        = (count_q == '0);
  assign full         = (count_q == FullLevel);
  assign almost_full  = (count_t'(count_q) >= AfLevel);
  assign almost_empty = (count_t'(count_q) <= AeLevel);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // A read frees a slot in the same cycle, so a full FIFO still takes a paired write.
  assign wr_acc = wr & (~full | rd);
  assign rd_acc = rd & ~empty;

  always_comb begin
    count_d = count_q;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CountOne;
      2'b01:   count_d = count_q - CountOne;
      default: count_d = count_q;
    endcase
  end

  // New errors win over a clear in the same cycle.
  assign overflow_d  = (overflow_q & ~clr_err) | (wr & full & ~rd);
  assign underflow_d = (underflow_q & ~clr_err) | (rd & empty);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr_q <= wr_ptr_q + PtrOne;
      end
      if (rd_acc) begin
        rd_ptr_q <= rd_ptr_q + PtrOne;
      end
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_dpram #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .REG_READ (RegRead)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc & ~rst),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .re    (rd_acc & ~rst),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

`ifdef UART_FIFO_FWFT_EN
  assign data_out = empty ? '0 : rdata;
`else
  assign data_out = rdata;
`endif

endmodule

// File: doc/uart_fifo_v2.md
Name: uart_fifo_v2

Overview:
Parametrised synchronous FIFO that succeeds the fixed 8x8 UART FIFO. It buffers the UART TX and RX byte streams between the baud-rate engines and the core-side register interface. Width and depth are configurable, and the block adds:
- an occupancy count,
- programmable almost-full and almost-empty flags,
- sticky overflow and underflow error flags,
- defined simultaneous read/write behaviour at the full and empty boundaries.

Parameters:
- WIDTH, 8, data word width in bits (1..32).
- DEPTH, 16, number of entries; must be a power of 2, range 2..256.
- AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH.
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH.
- Derived localparam AW = $clog2(DEPTH).

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wr  in  1  write request.
- data_in  in  WIDTH  write data.
- rd  in  1  read request.
- data_out  out  WIDTH  read data.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.
- count  out  AW+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.
- clr_err  in  1  clears overflow and underflow.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: while rst is high at a clock edge, the following registers clear:
  - wr_ptr = 0, rd_ptr = 0, count = 0, data_out = 0;
  - overflow = 0, underflow = 0.
  - Resulting outputs: empty = 1, full = 0, almost_empty = 1, almost_full = 0 (given AF_THRESH > 0).
  - Memory contents are not reset.
  - A reset asserted mid-stream discards all stored data; the wr/rd requests in that cycle are ignored.
- Acceptance rules:
  - wr_acc = wr & (~full | rd).
  - rd_acc = rd & ~empty.
- On wr_acc:
  - mem[wr_ptr] <= data_in;
  - wr_ptr increments and wraps DEPTH-1 -> 0 naturally (AW bits).
- On rd_acc (default mode):
  - data_out <= mem[rd_ptr], with 1-cycle latency: valid in the cycle after rd is sampled;
  - rd_ptr increments and wraps.
- data_out holds its last value when there is no rd_acc.
- count update: count <= count + wr_acc - rd_acc.
  - Simultaneous accepted read and write leaves count unchanged.
- Full with wr and rd together:
  - both are accepted; count stays DEPTH;
  - the read returns the old head before the slot is overwritten.
- Empty with wr and rd together:
  - the write is accepted; the read is rejected;
  - underflow is set; count becomes 1.
- Rejected requests:
  - wr while full without rd: data is dropped, pointers are unchanged, overflow <= 1.
  - rd while empty: pointers and data_out are unchanged, underflow <= 1.
- Error flags:
  - stay set until clr_err or rst;
  - if clr_err and a new error occur in the same cycle, the flag ends the cycle set (set wins).
- Flag timing: empty, full, almost_* are decoded from the registered count, so they update in the cycle after the causing edge.
- Pointer policy: no extra wrap bit is used; count disambiguates full from empty.

Optional Feature:
- Macro: UART_FIFO_FWFT_EN.
- Defined (first-word fall-through):
  - data_out = mem[rd_ptr] combinationally whenever empty = 0, so the head is visible before rd;
  - rd_acc pops the head and data_out shows the next entry in the following cycle;
  - data_out is don't-care while empty and is driven as 0 in that state.
- Undefined: the registered 1-cycle-latency read described above.

Decomposition:
- Package uart_fifo_pkg:
  - default WIDTH/DEPTH constants;
  - typedef for the count type;
  - a function that checks at elaboration that DEPTH is a power of 2.
- Sub-module fifo_dpram: simple dual-port RAM with one write port and one read port. It has a parameter that selects a registered or combinational read port, which serves the FWFT option. All pointer, count and flag logic stays in uart_fifo_v2.

Test Plan:
All scenarios use WIDTH=8, DEPTH=8, AF_THRESH=6, AE_THRESH=2 unless stated.
1. Underflow: after reset, rd=1 for 1 cycle -> underflow=1, count=0, data_out=0. Then clr_err=1 -> underflow=0.
2. Fill/overflow: write A1..A8 on consecutive cycles -> full=1, count=8, almost_full rises after the 6th write. Then write FF -> overflow=1, count=8, FF is not stored.
3. Drain order: read 8 times -> data_out sequence A1..A8, each 1 cycle after its rd. Then empty=1, almost_empty asserts once count<=2.
4. Simultaneous at full: with FIFO full of A1..A8, wr=1 (B1) and rd=1 together -> data_out=A1, count=8, no overflow. B1 is read last, after A8.
5. Wrap and reset: write/read 20 words interleaved to wrap the pointers twice -> order is preserved. Then assert rst with count=5 -> next cycle count=0, empty=1, and a subsequent read flags underflow.
6. FWFT build: write 5A -> data_out=5A before any rd. rd -> empty=1 on the next cycle.
